// File: rtl/data_memory_bytewise.sv
// Byte-addressable data RAM for the MEM stage: RV32 load/store formats, per-byte write enables,
// registered one-slot response with valid/ready handshake and error reporting.
module data_memory_bytewise #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0] mem_q [DEPTH];

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q,   resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  req_ready_s;
  logic                  fire_s;
  logic                  err_s;
  logic                  wr_en_s;
  logic [3:0]            wr_mask_s;
  logic [31:0]           wr_data_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [1:0]            off_s;
  logic                  hi_nz_s;
  logic [31:0]           rd_word_s;

  // Rejects misaligned, out-of-range and illegal-format accesses.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off, input logic hi_nz);
    logic e;
    case (f3)
      F3_B:    e = hi_nz;
      F3_H:    e = hi_nz | off[0];
      F3_W:    e = hi_nz | (off != 2'b00);
      F3_BU:   e = hi_nz | we;
      F3_HU:   e = hi_nz | we | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = 4'b0011 << off;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Request decode, handshake and response next-state.
  always_comb begin
    word_idx_s   = req_addr[ADDR_WIDTH+1:2];
    off_s        = req_addr[1:0];
    hi_nz_s      = |req_addr[31:ADDR_WIDTH+2];
    rd_word_s    = mem_q[word_idx_s];
    req_ready_s  = !resp_valid_q | resp_ready;
    fire_s       = req_valid & req_ready_s;
    err_s        = access_err(req_we, req_funct3, off_s, hi_nz_s);
    wr_mask_s    = byte_mask(req_funct3, off_s);
    wr_data_s    = lane_data(req_funct3, req_wdata);
    // A store presented during reset must not reach the array.
    wr_en_s      = fire_s & req_we & !err_s & !rst;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (fire_s) begin
      resp_valid_d = 1'b1;
      resp_err_d   = err_s;
      resp_rdata_d = (err_s | req_we) ? 32'h0000_0000 : load_extend(req_funct3, off_s, rd_word_s);
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0000_0000;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // Response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Byte-lane writes into the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && wr_mask_s[i]) begin
        mem_q[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Self-checking bench for data_memory_bytewise: directed RV32 load/store cases, randomized
// back-to-back traffic against a byte-array reference model, backpressure and reset-while-pending.
module tb_data_memory_bytewise;

  localparam int AW      = 10;
  localparam int NBYTES  = 4 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [0:NBYTES-1];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t dir_tab[$];

  data_memory_bytewise #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Reference: byte-addressed memory, accesses assembled little-endian byte by byte.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] er, output logic ee);
    int size;
    longint unsigned val;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    ee = (a >= 32'(NBYTES)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
         (we && f3 >= 3'd4) || ((a % size) != 0);
    er = 32'h0;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        val = 64'd0;
        for (int i = 0; i < size; i++) val |= longint'(ref_mem[a + i]) << (8 * i);
        if ((f3 == 3'd0 || f3 == 3'd1) && val[8*size-1]) val |= ~((64'd1 << (8 * size)) - 64'd1);
        er = val[31:0];
      end
    end
  endfunction

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.er = er; v.ee = ee;
    dir_tab.push_back(v);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1 ^ 1'b1, 1'b0, 32'h0}) begin
      $display("FAIL reset_resp: got v=%b e=%b d=%h want 0 0 00000000", resp_valid, resp_err, resp_rdata);
      miscompares++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", req_ready);
      miscompares++;
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] er;
    logic        ee;
    add(1, 3'b010, 32'h10, 32'h8000_00FF, 32'h0, 0);
    add(0, 3'b010, 32'h10, 32'h0,         32'h8000_00FF, 0);
    add(0, 3'b000, 32'h10, 32'h0,         32'hFFFF_FFFF, 0);
    add(0, 3'b000, 32'h11, 32'h0,         32'h0000_0000, 0);
    add(0, 3'b001, 32'h12, 32'h0,         32'hFFFF_8000, 0);
    add(1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0);
    add(1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 0);
    add(0, 3'b010, 32'h20, 32'h0,         32'h1122_AB44, 0);
    add(0, 3'b000, 32'h21, 32'h0,         32'hFFFF_FFAB, 0);
    add(0, 3'b100, 32'h21, 32'h0,         32'h0000_00AB, 0);
    add(1, 3'b010, 32'h30, 32'h0,         32'h0, 0);
    add(1, 3'b001, 32'h32, 32'h0000_8001, 32'h0, 0);
    add(0, 3'b001, 32'h32, 32'h0,         32'hFFFF_8001, 0);
    add(0, 3'b101, 32'h32, 32'h0,         32'h0000_8001, 0);
    add(0, 3'b010, 32'h30, 32'h0,         32'h8001_0000, 0);
    add(1, 3'b000, 32'h33, 32'h0000_007F, 32'h0, 0);
    add(0, 3'b010, 32'h30, 32'h0,         32'h7F01_0000, 0);
    add(0, 3'b000, 32'h33, 32'h0,         32'h0000_007F, 0);
    add(0, 3'b010, 32'h13, 32'h0,         32'h0, 1);
    add(1, 3'b001, 32'h11, 32'h0000_FFFF, 32'h0, 1);
    add(0, 3'b010, 32'h1000, 32'h0,       32'h0, 1);
    add(0, 3'b011, 32'h10, 32'h0,         32'h0, 1);
    add(1, 3'b100, 32'h20, 32'h0000_00FF, 32'h0, 1);
    add(1, 3'b110, 32'h30, 32'hFFFF_FFFF, 32'h0, 1);
    add(1, 3'b010, 32'h8000_0010, 32'h0,  32'h0, 1);
    add(0, 3'b010, 32'h10, 32'h0,         32'h8000_00FF, 0);
    add(0, 3'b010, 32'h20, 32'h0,         32'h1122_AB44, 0);
    add(0, 3'b010, 32'h30, 32'h0,         32'h7F01_0000, 0);
    foreach (dir_tab[k]) begin
      @(negedge clk);
      drive(dir_tab[k].we, dir_tab[k].f3, dir_tab[k].a, dir_tab[k].wd);
      resp_ready = 1'b1;
      model(dir_tab[k].we, dir_tab[k].f3, dir_tab[k].a, dir_tab[k].wd, er, ee);
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, dir_tab[k].ee, dir_tab[k].er}) begin
        $display("FAIL directed[%0d] addr=%h f3=%b we=%b: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                 k, dir_tab[k].a, dir_tab[k].f3, dir_tab[k].we, resp_valid, resp_err, resp_rdata,
                 dir_tab[k].ee, dir_tab[k].er);
        miscompares++;
      end
      @(negedge clk); req_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] er, a, wd;
    logic        ee, we;
    logic [2:0]  f3;
    int          r;
    resp_ready = 1'b1;
    for (int k = 0; k < 364; k++) begin
      if (k < 64) begin
        we = 1'b1; f3 = 3'b010; a = 32'(4 * k); wd = $urandom;
      end else begin
        r  = $urandom_range(0, 9);
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        a  = 32'($urandom_range(0, 255));
        if (r == 0) a = a + 32'h1000;
        else if (r == 1) a = a | 32'h8000_0000;
        else a = a;
      end
      @(negedge clk);
      drive(we, f3, a, wd);
      model(we, f3, a, wd, er, ee);
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, ee, er}) begin
        $display("FAIL b2b[%0d] addr=%h f3=%b we=%b: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                 k, a, f3, we, resp_valid, resp_err, resp_rdata, ee, er);
        miscompares++;
      end
    end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] er, held;
    logic        ee;
    @(negedge clk);
    drive(0, 3'b010, 32'h10, 32'h0);
    resp_ready = 1'b0;
    model(0, 3'b010, 32'h10, 32'h0, held, ee);
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, held}) begin
      $display("FAIL bp_load: got v=%b e=%b d=%h want 1 0 %h", resp_valid, resp_err, resp_rdata, held);
      miscompares++;
    end
    @(negedge clk);
    // Held store aimed at 0x44; it is swapped for 0x48 on release, so 0x44 must stay intact.
    drive(1, 3'b010, 32'h44, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
        $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready);
        miscompares++;
      end
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, held}) begin
        $display("FAIL bp_hold[%0d]: got v=%b e=%b d=%h want 1 0 %h", i, resp_valid, resp_err, resp_rdata, held);
        miscompares++;
      end
      @(negedge clk);
    end
    drive(1, 3'b010, 32'h48, 32'h5A5A_0002);
    resp_ready = 1'b1;
    model(1, 3'b010, 32'h48, 32'h5A5A_0002, er, ee);
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL bp_release: got v=%b e=%b d=%h want 1 0 00000000", resp_valid, resp_err, resp_rdata);
      miscompares++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 3'b010, (i == 0) ? 32'h44 : 32'h48, 32'h0);
      model(0, 3'b010, req_addr, 32'h0, er, ee);
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, er}) begin
        $display("FAIL bp_readback @%h: got v=%b e=%b d=%h want 1 0 %h", req_addr, resp_valid, resp_err, resp_rdata, er);
        miscompares++;
      end
    end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_reset_pending;
    logic [31:0] er;
    logic        ee;
    @(negedge clk);
    drive(0, 3'b010, 32'h50, 32'h0);
    resp_ready = 1'b0;
    model(0, 3'b010, 32'h50, 32'h0, er, ee);
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b1) begin
      $display("FAIL rstp_pending: got v=%b want 1", resp_valid);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    resp_ready = 1'b1;
    drive(1, 3'b010, 32'h50, ~er);
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL rstp_outputs: got v=%b e=%b d=%h want 0 0 00000000", resp_valid, resp_err, resp_rdata);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    drive(0, 3'b010, 32'h50, 32'h0);
    model(0, 3'b010, 32'h50, 32'h0, er, ee);
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, er}) begin
      $display("FAIL rstp_store_absent: got v=%b e=%b d=%h want 1 0 %h", resp_valid, resp_err, resp_rdata, er);
      miscompares++;
    end
    @(negedge clk); req_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_backpressure;
    test_reset_pending;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
